fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 19-bit pipelined CPU. Owns the program counter and drives
//   InstMem's PC input; InstMem returns the instruction combinationally in the
//   same cycle. Latches instruction + PC+1 into the IF/ID register for decode.
//   Takes stall, branch-redirect and halt from the hazard/branch/decode logic.
// PARAMETERS
//   PC_W     12          PC width; InstMem depth = 2**PC_W words
//   INSTR_W  19          instruction width
//   RESET_PC 12'd0       first fetch address after reset
//   NOP      19'd0       bubble value written to IF/ID on flush/halt/boot
// PORTS
//   clk            in   1        rising-edge clock
//   rst            in   1        asynchronous reset, active-high
//   stall          in   1        hold PC and IF/ID (load-use hazard)
//   redirect       in   1        branch/jump taken; load PC from redirect_pc
//   redirect_pc    in   PC_W     target address
//   halt           in   1        decode saw HALT; stop fetching until reset
//   imem_pc        out  PC_W     address to InstMem (= PC register)
//   imem_instr     in   INSTR_W  InstMem read data (combinational)
//   ifid_instr     out  INSTR_W  registered instruction to decode
//   ifid_pc1       out  PC_W     registered PC+1 of that instruction
//   ifid_valid     out  1        ifid_instr is a real instruction
//   fetch_count    out  16       number of valid instructions latched (saturating)
// BEHAVIOUR
//   Reset (async, any time incl. mid-stall/mid-redirect): pc=RESET_PC,
//     ifid_instr=NOP, ifid_pc1=0, ifid_valid=0, fetch_count=0, state=BOOT.
//   FSM states BOOT, RUN, HALTED:
//     BOOT   -> RUN after one cycle; no IF/ID load, pc holds RESET_PC.
//     RUN    -> HALTED when halt=1 sampled at clk edge.
//     HALTED -> only rst exits; pc frozen, ifid_valid=0, ifid_instr=NOP.
//   RUN, per edge, priority redirect > stall > normal:
//     redirect=1: pc<=redirect_pc; ifid_instr<=NOP; ifid_valid<=0
//       (squash wrong-path fetch; overrides stall in the same cycle).
//     stall=1 (no redirect): pc, ifid_* and fetch_count all hold.
//     normal: ifid_instr<=imem_instr; ifid_pc1<=pc+1; ifid_valid<=1;
//       pc<=pc+1; fetch_count<=fetch_count+1.
//   halt and redirect in same cycle: halt wins (enter HALTED, pc unchanged).
//   Arithmetic: pc+1 modulo 2**PC_W (4095 -> 0 wrap, ifid_pc1=0 at wrap).
//   fetch_count saturates at 16'hFFFF, never wraps.
//   imem_pc = pc register, no combinational path from inputs to imem_pc.
//   Fetch latency: instruction at address A appears on ifid_* one edge after
//     pc==A with stall=0; first valid ifid after reset is on the 2nd edge.
//   Inputs sampled only in RUN; stall/redirect ignored in BOOT and HALTED.
// TESTING
//   1 Reset, ROM[0..3]=distinct, no stall -> edge2 ifid_instr=ROM[0],
//     ifid_pc1=1, valid=1; edge3 ROM[1]; fetch_count=3 after edge4.
//   2 stall high 2 cycles while pc=5 -> pc stays 5, ifid/fetch_count
//     unchanged; after release ifid_instr=ROM[5].
//   3 redirect=1, redirect_pc=12'd40 with stall=1 -> next edge pc=40,
//     ifid_valid=0, ifid_instr=NOP; following edge ifid_instr=ROM[40].
//   4 pc forced to 4095 by redirect -> ifid_instr=ROM[4095], ifid_pc1=0,
//     next pc=0.
//   5 halt=1 together with redirect -> state HALTED, pc unchanged, valid=0
//     forever; assert rst mid-cycle -> all outputs reset immediately.
//   6 rst asserted asynchronously between edges during RUN -> pc=0,
//     ifid_valid=0 before next edge; BOOT then normal fetch from 0.

Source files
------------

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
//   Groups the IF stage's control inputs, its InstMem port and its IF/ID
//   outputs into one bundle.
//   master : the fetch stage. It drives imem_pc, ifid_* and fetch_count, and
//            receives stall/redirect/halt and imem_instr.
//   slave  : the surrounding pipeline and InstMem. This is the opposite view.
//   Signals:
//     stall        hold PC and IF/ID (load-use hazard)
//     redirect     branch/jump taken; load PC from redirect_pc
//     redirect_pc  redirect target address
//     halt         decode saw HALT; stop fetching until reset
//     imem_pc      InstMem address (the PC register)
//     imem_instr   InstMem read data (combinational in the same cycle)
//     ifid_instr   registered instruction to decode
//     ifid_pc1     registered PC+1 of that instruction
//     ifid_valid   ifid_instr is a real instruction
//     fetch_count  saturating count of valid instructions latched
// ---------------------------------------------------------------------------
interface fetch_if #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19
);
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;
  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc1;
  logic               ifid_valid;
  logic [15:0]        fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, halt, imem_instr,
    output imem_pc, ifid_instr, ifid_pc1, ifid_valid, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, halt, imem_instr,
    input  imem_pc, ifid_instr, ifid_pc1, ifid_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage of the 19-bit pipelined CPU. It owns the program counter and
//   presents it to InstMem. It latches the returned instruction and PC+1 into
//   the IF/ID register. It obeys stall, branch redirect and halt.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   fetch_if.master. It carries the control inputs, the InstMem port
//           and the IF/ID outputs.
//   FSM:
//     BOOT   spends one cycle after reset with no IF/ID load.
//     RUN    fetches. Priority is halt > redirect > stall > normal.
//     HALTED freezes the PC and presents a bubble. Only reset leaves it.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                 PC_W     = 12,
  parameter int                 INSTR_W  = 19,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP      = '0
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             r_state,      w_state_next;
  logic [PC_W-1:0]    r_pc,         w_pc_next;
  logic [INSTR_W-1:0] r_ifid_instr, w_ifid_instr_next;
  logic [PC_W-1:0]    r_ifid_pc1,   w_ifid_pc1_next;
  logic               r_ifid_valid, w_ifid_valid_next;
  logic [15:0]        r_count,      w_count_next;

  // PC+1 wraps naturally at 2**PC_W because the result has PC_W bits.
  logic [PC_W-1:0]    w_pc_inc;
  assign w_pc_inc = r_pc + PC_W'(1);

  // State register and the IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP;
      r_ifid_pc1   <= '0;
      r_ifid_valid <= 1'b0;
      r_count      <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pc1   <= w_ifid_pc1_next;
      r_ifid_valid <= w_ifid_valid_next;
      r_count      <= w_count_next;
    end
  end

  // Next-state logic. Every value holds unless a branch below changes it.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_pc1_next   = r_ifid_pc1;
    w_ifid_valid_next = r_ifid_valid;
    w_count_next      = r_count;

    case (r_state)
      ST_BOOT: begin
        // Stall, redirect and halt are ignored here.
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.halt) begin
          // Halt beats a simultaneous redirect, so the PC stays where it is.
          w_state_next      = ST_HALTED;
          w_ifid_instr_next = NOP;
          w_ifid_valid_next = 1'b0;
        end else if (bus.redirect) begin
          // Squash the wrong-path fetch. This applies even during a stall.
          w_pc_next         = bus.redirect_pc;
          w_ifid_instr_next = NOP;
          w_ifid_valid_next = 1'b0;
        end else if (!bus.stall) begin
          w_pc_next         = w_pc_inc;
          w_ifid_instr_next = bus.imem_instr;
          w_ifid_pc1_next   = w_pc_inc;
          w_ifid_valid_next = 1'b1;
          // The count saturates rather than wrapping.
          if (r_count != 16'hFFFF) begin
            w_count_next = r_count + 16'd1;
          end
        end
      end

      ST_HALTED: begin
        w_ifid_instr_next = NOP;
        w_ifid_valid_next = 1'b0;
      end

      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // InstMem sees the PC register directly, so no input reaches it
  // combinationally.
  assign bus.imem_pc     = r_pc;
  assign bus.ifid_instr  = r_ifid_instr;
  assign bus.ifid_pc1    = r_ifid_pc1;
  assign bus.ifid_valid  = r_ifid_valid;
  assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [18:0] rom [0:4095];

  fetch_if #(.PC_W(12), .INSTR_W(19)) bus ();

  assign bus.imem_instr = rom[bus.imem_pc];

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct ROM word per address: a*37 + 0x1234 stays below 2**19.
  function automatic logic [18:0] rom_val(input int a);
    return 19'(a * 37 + 32'h1234);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] pc, input logic valid,
                         input logic [18:0] instr, input logic [15:0] cnt);
    check({tag, ".pc"},    32'(bus.imem_pc),     32'(pc));
    check({tag, ".valid"}, 32'(bus.ifid_valid),  32'(valid));
    check({tag, ".instr"}, 32'(bus.ifid_instr),  32'(instr));
    check({tag, ".count"}, 32'(bus.fetch_count), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) rom[i] = rom_val(i);

    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 12'd0;
    bus.halt        = 1'b0;

    // Reset state
    #3;
    chk_all("reset", 12'd0, 1'b0, 19'd0, 16'd0);
    check("reset.pc1", 32'(bus.ifid_pc1), 32'd0);
    step();
    rst = 1'b0;

    // 1: BOOT, then sequential fetch
    step();
    chk_all("t1.boot", 12'd0, 1'b0, 19'd0, 16'd0);
    step();
    chk_all("t1.e2", 12'd1, 1'b1, rom_val(0), 16'd1);
    check("t1.e2.pc1", 32'(bus.ifid_pc1), 32'd1);
    step();
    chk_all("t1.e3", 12'd2, 1'b1, rom_val(1), 16'd2);
    step();
    chk_all("t1.e4", 12'd3, 1'b1, rom_val(2), 16'd3);
    step();
    step();
    chk_all("t1.e6", 12'd5, 1'b1, rom_val(4), 16'd5);

    // 2: stall for two cycles at pc=5
    bus.stall = 1'b1;
    step();
    chk_all("t2.s1", 12'd5, 1'b1, rom_val(4), 16'd5);
    step();
    chk_all("t2.s2", 12'd5, 1'b1, rom_val(4), 16'd5);
    bus.stall = 1'b0;
    step();
    chk_all("t2.rel", 12'd6, 1'b1, rom_val(5), 16'd6);
    check("t2.rel.pc1", 32'(bus.ifid_pc1), 32'd6);

    // 3: redirect overrides stall
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'd40;
    step();
    chk_all("t3.redir", 12'd40, 1'b0, 19'd0, 16'd6);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    chk_all("t3.next", 12'd41, 1'b1, rom_val(40), 16'd7);
    check("t3.next.pc1", 32'(bus.ifid_pc1), 32'd41);

    // 4: PC wraps from 4095 to 0
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'd4095;
    step();
    chk_all("t4.redir", 12'd4095, 1'b0, 19'd0, 16'd7);
    bus.redirect = 1'b0;
    step();
    chk_all("t4.wrap", 12'd0, 1'b1, rom_val(4095), 16'd8);
    check("t4.wrap.pc1", 32'(bus.ifid_pc1), 32'd0);
    step();
    chk_all("t4.after", 12'd1, 1'b1, rom_val(0), 16'd9);

    // 5: halt beats redirect; HALTED holds until reset
    bus.halt = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'd100;
    step();
    chk_all("t5.halt", 12'd1, 1'b0, 19'd0, 16'd9);
    bus.halt = 1'b0;
    bus.redirect_pc = 12'd200;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("t5.held", 12'd1, 1'b0, 19'd0, 16'd9);
    end
    bus.redirect = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("t5.rst", 12'd0, 1'b0, 19'd0, 16'd0);
    check("t5.rst.pc1", 32'(bus.ifid_pc1), 32'd0);
    step();
    rst = 1'b0;
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'd77;
    step();
    chk_all("t5.boot", 12'd0, 1'b0, 19'd0, 16'd0);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    chk_all("t5.f0", 12'd1, 1'b1, rom_val(0), 16'd1);
    step();
    chk_all("t5.f1", 12'd2, 1'b1, rom_val(1), 16'd2);

    // 6: asynchronous reset between edges during RUN
    #3;
    rst = 1'b1;
    #1;
    chk_all("t6.rst", 12'd0, 1'b0, 19'd0, 16'd0);
    #1;
    rst = 1'b0;
    step();
    chk_all("t6.boot", 12'd0, 1'b0, 19'd0, 16'd0);
    step();
    chk_all("t6.f0", 12'd1, 1'b1, rom_val(0), 16'd1);

    // fetch_count saturation
    for (int k = 0; k < 65533; k++) step();
    check("sat.fffe", 32'(bus.fetch_count), 32'hFFFE);
    step();
    check("sat.ffff", 32'(bus.fetch_count), 32'hFFFF);
    check("sat.pc", 32'(bus.imem_pc), 32'd4095);
    step();
    chk_all("sat.hold", 12'd0, 1'b1, rom_val(4095), 16'hFFFF);
    check("sat.pc1", 32'(bus.ifid_pc1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
